// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port IDs and default memory size.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int MEM_BYTES_DEF = 64;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker; remembers the last granted port so ties alternate.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_grant_r;

    // Grant the lone requester, or on a tie the port that did not win last time
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && (!req_b || (last_grant_r == PORT_B))) begin
            gnt_a = 1'b1;
        end else if (req_b) begin
            gnt_b = 1'b1;
        end else begin
            gnt_b = 1'b0;
        end
    end

    // Record the winner only when the grant is actually taken
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_r <= PORT_B;
        end else if (advance && gnt_a) begin
            last_grant_r <= PORT_A;
        end else if (advance && gnt_b) begin
            last_grant_r <= PORT_B;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port request/acknowledge sequencer in front of data_mem: one clean strobe per access,
// misaligned or out-of-range word addresses rejected without touching memory.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= ADDR_W'(MEM_BYTES - 4));
    endfunction

    state_t            state_r, state_s;
    logic              port_r, port_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic              memread_r, memread_s, memwrite_r, memwrite_s;
    logic              a_ack_r, a_ack_s, b_ack_r, b_ack_s;
    logic              a_err_r, a_err_s, b_err_r, b_err_s;
    logic [DATA_W-1:0] a_rdata_r, a_rdata_s, b_rdata_r, b_rdata_s;
    logic              busy_r, busy_s;
    logic              finish_s, fin_err_s, fin_load_s;
    logic [DATA_W-1:0] fin_data_s;
    logic              gnt_a_s, gnt_b_s, advance_s;

    assign advance_s = (state_r == IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_a   (a_req),
        .req_b   (b_req),
        .advance (advance_s),
        .gnt_a   (gnt_a_s),
        .gnt_b   (gnt_b_s)
    );

    // Next state plus next value of every registered output
    always_comb begin
        state_s    = state_r;
        port_s     = port_r;
        we_s       = we_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        memread_s  = 1'b0;
        memwrite_s = 1'b0;
        a_ack_s    = 1'b0;
        b_ack_s    = 1'b0;
        a_err_s    = a_err_r;
        b_err_s    = b_err_r;
        a_rdata_s  = a_rdata_r;
        b_rdata_s  = b_rdata_r;
        finish_s   = 1'b0;
        fin_err_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (gnt_a_s) begin
                    port_s  = PORT_A;
                    we_s    = a_we;
                    addr_s  = a_addr;
                    wdata_s = a_wdata;
                    state_s = SETUP;
                end else if (gnt_b_s) begin
                    port_s  = PORT_B;
                    we_s    = b_we;
                    addr_s  = b_addr;
                    wdata_s = b_wdata;
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (!addr_ok(addr_r)) begin
                    state_s   = DONE;
                    finish_s  = 1'b1;
                    fin_err_s = 1'b1;
                end else begin
                    state_s    = STROBE;
                    memread_s  = !we_r;
                    memwrite_s = we_r;
                end
            end
            STROBE: begin
                // Read data is captured as the FSM enters DONE so it lines up with the ack
                state_s  = DONE;
                finish_s = 1'b1;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        fin_load_s = fin_err_s || !we_r;
        fin_data_s = fin_err_s ? {DATA_W{1'b0}} : mem_read_data;
        if (finish_s && (port_r == PORT_A)) begin
            a_ack_s = 1'b1;
            a_err_s = fin_err_s;
            if (fin_load_s) begin
                a_rdata_s = fin_data_s;
            end else begin
                a_rdata_s = a_rdata_r;
            end
        end else if (finish_s) begin
            b_ack_s = 1'b1;
            b_err_s = fin_err_s;
            if (fin_load_s) begin
                b_rdata_s = fin_data_s;
            end else begin
                b_rdata_s = b_rdata_r;
            end
        end else begin
            a_ack_s = 1'b0;
        end
        busy_s = (state_s != IDLE);
    end

    // State, transaction latches and all outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            port_r     <= PORT_A;
            we_r       <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            a_ack_r    <= 1'b0;
            b_ack_r    <= 1'b0;
            a_err_r    <= 1'b0;
            b_err_r    <= 1'b0;
            a_rdata_r  <= {DATA_W{1'b0}};
            b_rdata_r  <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            port_r     <= port_s;
            we_r       <= we_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            memread_r  <= memread_s;
            memwrite_r <= memwrite_s;
            a_ack_r    <= a_ack_s;
            b_ack_r    <= b_ack_s;
            a_err_r    <= a_err_s;
            b_err_r    <= b_err_s;
            a_rdata_r  <= a_rdata_s;
            b_rdata_r  <= b_rdata_s;
            busy_r     <= busy_s;
        end
    end

    assign mem_address    = addr_r;
    assign mem_write_data = wdata_r;
    assign mem_memread    = memread_r;
    assign mem_memwrite   = memwrite_r;
    assign a_ack          = a_ack_r;
    assign a_err          = a_err_r;
    assign a_rdata        = a_rdata_r;
    assign b_ack          = b_ack_r;
    assign b_err          = b_err_r;
    assign b_rdata        = b_rdata_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural data_mem, transaction-level reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [31:0] a_addr = 32'd0, a_wdata = 32'd0, b_addr = 32'd0, b_wdata = 32'd0;
    logic        a_ack, a_err, b_ack, b_err, mem_memread, mem_memwrite, busy;
    logic [31:0] a_rdata, b_rdata, mem_address, mem_write_data;
    logic [31:0] mem_read_data = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at cycle-time %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural data_mem: 64 bytes, big-endian, acts on strobe rising edges
    logic [7:0] env_mem [0:63];
    logic [7:0] mdl_mem [0:63];
    initial begin
        for (int i = 0; i < 16; i++) begin
            env_mem[4*i] = 8'hfc; env_mem[4*i+1] = 8'h20; env_mem[4*i+2] = 8'h00; env_mem[4*i+3] = 8'(4*i);
            mdl_mem[4*i] = 8'hfc; mdl_mem[4*i+1] = 8'h20; mdl_mem[4*i+2] = 8'h00; mdl_mem[4*i+3] = 8'(4*i);
        end
    end
    always @(posedge mem_memread) begin
        if (mem_address <= 32'd60)
            mem_read_data = {env_mem[mem_address], env_mem[mem_address+1], env_mem[mem_address+2], env_mem[mem_address+3]};
    end
    always @(posedge mem_memwrite) begin
        if (mem_address <= 32'd60) begin
            env_mem[mem_address]   = mem_write_data[31:24];
            env_mem[mem_address+1] = mem_write_data[23:16];
            env_mem[mem_address+2] = mem_write_data[15:8];
            env_mem[mem_address+3] = mem_write_data[7:0];
        end
    end

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return {mdl_mem[a], mdl_mem[a+1], mdl_mem[a+2], mdl_mem[a+3]};
    endfunction

    // Transaction-level reference model: expected outputs for the next cycle
    int          cyc = 0;
    bit          chk_en = 1'b0;
    bit          pending = 1'b0, last_g = 1'b1;
    int          p_g, p_ack;
    bit          p_port, p_we, p_err;
    logic [31:0] p_addr, p_wdata;
    logic        exp_a_ack, exp_b_ack, exp_a_err, exp_b_err, exp_rd, exp_wr, exp_busy;
    logic [31:0] exp_a_rdata, exp_b_rdata, exp_addr, exp_wdata;

    always @(posedge clk) begin
        int c;
        c = cyc;
        exp_a_ack = 1'b0; exp_b_ack = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
        if (pending && !p_err && p_we && c == p_g + 2) begin
            mdl_mem[p_addr] = p_wdata[31:24]; mdl_mem[p_addr+1] = p_wdata[23:16];
            mdl_mem[p_addr+2] = p_wdata[15:8]; mdl_mem[p_addr+3] = p_wdata[7:0];
        end
        if (!reset) begin
            chk_en = 1'b1; pending = 1'b0; last_g = 1'b1;
            exp_a_err = 1'b0; exp_b_err = 1'b0; exp_a_rdata = 32'd0; exp_b_rdata = 32'd0;
            exp_addr = 32'd0; exp_wdata = 32'd0; exp_busy = 1'b0;
        end else if (pending) begin
            if (c == p_ack) begin
                pending = 1'b0; exp_busy = 1'b0;
            end else begin
                if (c + 1 == p_g + 2 && !p_err) begin exp_rd = !p_we; exp_wr = p_we; end
                if (c + 1 == p_ack) begin
                    if (p_port == 1'b0) begin
                        exp_a_ack = 1'b1; exp_a_err = p_err;
                        if (p_err) exp_a_rdata = 32'd0; else if (!p_we) exp_a_rdata = mdl_rd(p_addr);
                    end else begin
                        exp_b_ack = 1'b1; exp_b_err = p_err;
                        if (p_err) exp_b_rdata = 32'd0; else if (!p_we) exp_b_rdata = mdl_rd(p_addr);
                    end
                end
            end
        end else if (a_req || b_req) begin
            p_port  = (a_req && b_req) ? !last_g : !a_req;
            last_g  = p_port;
            p_we    = p_port ? b_we : a_we;
            p_addr  = p_port ? b_addr : a_addr;
            p_wdata = p_port ? b_wdata : a_wdata;
            p_err   = (p_addr % 4 != 0) || (p_addr > 32'd60);
            p_g     = c;
            p_ack   = c + (p_err ? 2 : 3);
            pending = 1'b1; exp_busy = 1'b1;
            exp_addr = p_addr; exp_wdata = p_wdata;
        end else begin
            exp_busy = 1'b0;
        end
        cyc = c + 1;
    end

    // Per-cycle compare against the model plus strobe-shape rules
    bit prev_strobe = 1'b0;
    int rd_count = 0, wr_count = 0, last_rd_cyc = -1;
    bit ack_order [$];
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_ack", {31'd0, a_ack}, {31'd0, exp_a_ack});
            check("b_ack", {31'd0, b_ack}, {31'd0, exp_b_ack});
            check("a_err", {31'd0, a_err}, {31'd0, exp_a_err});
            check("b_err", {31'd0, b_err}, {31'd0, exp_b_err});
            check("a_rdata", a_rdata, exp_a_rdata);
            check("b_rdata", b_rdata, exp_b_rdata);
            check("memread", {31'd0, mem_memread}, {31'd0, exp_rd});
            check("memwrite", {31'd0, mem_memwrite}, {31'd0, exp_wr});
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("mem_address", mem_address, exp_addr);
            check("mem_write_data", mem_write_data, exp_wdata);
            check("one_strobe", {31'd0, mem_memread & mem_memwrite}, 32'd0);
            check("no_back_to_back", {31'd0, prev_strobe & (mem_memread | mem_memwrite)}, 32'd0);
            prev_strobe = mem_memread | mem_memwrite;
            if (mem_memread) begin rd_count++; last_rd_cyc = cyc; end
            if (mem_memwrite) wr_count++;
            if (a_ack) ack_order.push_back(1'b0);
            if (b_ack) ack_order.push_back(1'b1);
        end
    end

    task automatic xact(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, output logic [31:0] rdata, output bit err, output int lat, output int t0);
        bit got;
        int n;
        @(posedge clk); #1;
        if (port == 1'b0) begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
        else begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
        t0 = cyc; got = 1'b0; n = 0; rdata = 32'hx; err = 1'b0;
        while (!got && n < 12) begin
            @(negedge clk); n++;
            if (port == 1'b0 ? a_ack : b_ack) begin
                got = 1'b1;
                rdata = port ? b_rdata : a_rdata;
                err = port ? b_err : a_err;
            end
        end
        lat = cyc - t0;
        check("ack_within_bound", {31'd0, got}, 32'd1);
        if (!hold) begin
            @(posedge clk); #1;
            if (port == 1'b0) a_req = 1'b0; else b_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bit er;
        int lat, t0, rd0, wr0;
        bit exp_order [4];
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_addr", mem_address, 32'd0);
        check("reset_a_rdata", a_rdata, 32'd0);
        reset = 1'b1;
        @(posedge clk);

        // A read at 4
        rd0 = rd_count;
        xact(1'b0, 1'b0, 32'd4, 32'd0, 1'b0, rd, er, lat, t0);
        check("rd4_data", rd, 32'hfc200004);
        check("rd4_err", {31'd0, er}, 32'd0);
        check("rd4_latency", lat, 32'd3);
        check("rd4_strobe_cycle", last_rd_cyc - t0, 32'd2);
        check("rd4_strobe_count", rd_count - rd0, 32'd1);

        // A write 16 then B read 16
        wr0 = wr_count;
        xact(1'b0, 1'b1, 32'd16, 32'hdeadbeef, 1'b0, rd, er, lat, t0);
        check("wr16_count", wr_count - wr0, 32'd1);
        check("wr16_a_rdata_kept", rd, 32'hfc200004);
        xact(1'b1, 1'b0, 32'd16, 32'd0, 1'b0, rd, er, lat, t0);
        check("rd16_b_data", rd, 32'hdeadbeef);

        // Contention: both request together, then re-request immediately
        ack_order.delete();
        fork
            begin
                logic [31:0] r1; bit e1; int l1, s1;
                xact(1'b0, 1'b0, 32'd8, 32'd0, 1'b1, r1, e1, l1, s1);
                xact(1'b0, 1'b0, 32'd12, 32'd0, 1'b0, r1, e1, l1, s1);
                check("cont_a_rd12", r1, 32'hfc20000c);
            end
            begin
                logic [31:0] r2; bit e2; int l2, s2;
                xact(1'b1, 1'b1, 32'd24, 32'hcafef00d, 1'b1, r2, e2, l2, s2);
                xact(1'b1, 1'b0, 32'd24, 32'd0, 1'b0, r2, e2, l2, s2);
                check("cont_b_rd24", r2, 32'hcafef00d);
            end
        join
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        check("cont_ack_count", ack_order.size(), 32'd4);
        for (int i = 0; i < 4 && i < ack_order.size(); i++)
            check($sformatf("cont_order_%0d", i), {31'd0, ack_order[i]}, {31'd0, exp_order[i]});

        // Errors: misaligned read, out-of-range write
        rd0 = rd_count; wr0 = wr_count;
        xact(1'b0, 1'b0, 32'd6, 32'd0, 1'b0, rd, er, lat, t0);
        check("err6_flag", {31'd0, er}, 32'd1);
        check("err6_latency", lat, 32'd2);
        check("err6_rdata", rd, 32'd0);
        xact(1'b1, 1'b1, 32'd64, 32'h11112222, 1'b0, rd, er, lat, t0);
        check("err64_flag", {31'd0, er}, 32'd1);
        check("err64_latency", lat, 32'd2);
        check("err64_rdata", rd, 32'd0);
        check("err_no_strobes", (rd_count - rd0) + (wr_count - wr0), 32'd0);

        // Reset asserted during the strobe of a write
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'd20; a_wdata = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_strobe_high", {31'd0, mem_memwrite}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        a_req = 1'b0;
        check("rst_mid_memwrite", {31'd0, mem_memwrite}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_ack", {31'd0, a_ack}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        xact(1'b1, 1'b0, 32'd20, 32'd0, 1'b0, rd, er, lat, t0);
        check("rst_mid_write_landed", rd, 32'h12345678);
        check("rd20_latency", lat, 32'd3);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port request/acknowledge arbiter and sequencer in front of `data_mem`.
- `data_mem` is byte-addressed, 64 bytes, big-endian word access, and acts on rising edges of `memread`/`memwrite`.
- Shares the memory between port A (core load/store) and port B (debug/loader), generates clean one-cycle strobes, and rejects misaligned or out-of-range accesses.
- Sits between the core MEM stage, the debug port and `data_mem`.

Parameters:
- `MEM_BYTES`, 64, byte size of `data_mem`. Legal word addresses are 0..`MEM_BYTES`-4.
- `ADDR_W`, 32, address width on all ports.
- `DATA_W`, 32, data width on all ports.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous reset, active-low (sampled on `clk` rising edge).
- `a_req`  in  1  port A request, held until `a_ack`.
- `a_we`  in  1  port A: 1 = write, 0 = read.
- `a_addr`  in  `ADDR_W`  port A byte address.
- `a_wdata`  in  `DATA_W`  port A write data.
- `a_ack`  out  1  port A one-cycle completion pulse.
- `a_err`  out  1  port A error, valid with `a_ack`.
- `a_rdata`  out  `DATA_W`  port A read data, valid with `a_ack`.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_err`, `b_rdata`: same as port A, for port B.
- `mem_address`  out  `ADDR_W`  to `data_mem` `address`.
- `mem_write_data`  out  `DATA_W`  to `data_mem` `write_data`.
- `mem_memread`  out  1  to `data_mem` `memread`.
- `mem_memwrite`  out  1  to `data_mem` `memwrite`.
- `mem_read_data`  in  `DATA_W`  from `data_mem` `read_data`.
- `busy`  out  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (`reset`=0 at an edge):
  - state=IDLE; `last_grant`=B, so A wins the first tie.
  - All acks, errs, strobes and `busy` = 0.
  - `mem_address`, `mem_write_data`, `a_rdata`, `b_rdata` = 0.
- Reset mid-transaction: the transaction is dropped with no ack, and strobes are low from the next edge. Memory contents written before reset are not restored by this block.
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant it.
  - Both reqs: grant the port not equal to `last_grant`, then update `last_grant`.
  - On grant: latch we, addr and wdata of the granted port, then go to SETUP.
- SETUP: drive `mem_address`/`mem_write_data`, strobes low.
  - Error if addr[1:0]!=0 or addr>`MEM_BYTES`-4; then go to DONE with err flag set and issue no strobe.
  - Otherwise go to STROBE.
- STROBE: exactly one cycle with `mem_memread`=!we or `mem_memwrite`=we; address and data held stable. Go to DONE.
- DONE:
  - Strobes low; address held.
  - For a read, sample `mem_read_data` into the granted port's rdata.
  - Pulse the granted port's ack for one cycle, with err=err flag.
  - On error, rdata=0. For a write, rdata keeps its previous value.
  - Go to IDLE.
- Latency, with the request first visible in IDLE at cycle 0:
  - Good access: ack at cycle 3.
  - Errored access: ack at cycle 2.
  - Throughput: one access per 4 cycles.
- Handshake:
  - Requester holds req, we, addr and wdata stable until ack.
  - Req seen in the cycle after ack is a new request.
  - Deasserting req before ack is illegal; the transaction still completes.
- Never more than one strobe high. Strobes are never high in consecutive cycles, which guarantees a rising edge per access.
- Non-granted port's inputs are ignored. Its ack, err and rdata are unchanged.
- Data passes through unmodified; byte order is `data_mem`'s big-endian.
- Under continuous contention, A and B alternate grants.

Decomposition:
- Shared package `dmem_pkg`:
  - state encoding (IDLE=0, SETUP=1, STROBE=2, DONE=3);
  - port ID constants (`PORT_A`=0, `PORT_B`=1);
  - `MEM_BYTES` default.
- One natural sub-module: `rr_arb2`, the 2-way round-robin picker holding `last_grant`. Inputs: `clk`, `reset`, `req_a`, `req_b`, `advance`. Outputs: `gnt_a`, `gnt_b`.
- FSM, latches and range check stay in the top module.

Test Plan:
- After reset, A read at addr 4 → `mem_memread` is high only in cycle 2. `a_ack` fires in cycle 3 with `a_rdata`=32'hfc200004 and `a_err`=0.
- A write 32'hdeadbeef at addr 16, then B read at addr 16 → `mem_memwrite` pulses once. `b_rdata`=32'hdeadbeef.
- `a_req` and `b_req` high together in the same cycle, looped 4 times → grant order A, B, A, B. Exactly one ack per transaction; no two strobes overlap.
- A read at addr 6, then B write at addr 64 → each ack arrives 2 cycles after grant with err=1. No strobe is issued; rdata=0; memory is unchanged.
- `reset` driven low during STROBE of a write → strobes are 0 and state is IDLE next cycle. No ack is issued, and `busy`=0.
